// File: rtl/iocontroller_mc.sv
// Multi-channel syscall I/O controller: decodes acc into opcode/channel and runs a 4-phase
// req/ack handshake on one peripheral channel. Optional ack timeout under `IO_TIMEOUT_EN`.
module iocontroller_mc #(
    parameter int DATA_W    = 16,
    parameter int NCHAN     = 4,
    parameter int CHAN_W    = 2,
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              runio,
    input  logic [DATA_W-1:0] acc,
    input  logic [NCHAN-1:0]  ioack,
    output logic              iobusy,
    output logic [NCHAN-1:0]  io_read,
    output logic [NCHAN-1:0]  io_write,
    output logic              acc_write,
    output logic              halted,
    output logic              ioerr,
    output logic [1:0]        err_code
);

    typedef enum logic [1:0] {
        ST_DECODE    = 2'd0,
        ST_WAITACK   = 2'd1,
        ST_WAITREADY = 2'd2,
        ST_HALT      = 2'd3
    } state_t;

    localparam logic [3:0] OP_HALT  = 4'd0;
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;

    localparam logic [1:0] ERR_OPCODE  = 2'd1;
    localparam logic [1:0] ERR_CHANNEL = 2'd2;

    state_t              state_r;
    logic [CHAN_W-1:0]   ch_r;
    logic                err_done_r;
    logic                iobusy_r;
    logic [NCHAN-1:0]    io_read_r;
    logic [NCHAN-1:0]    io_write_r;
    logic                acc_write_r;
    logic                halted_r;
    logic                ioerr_r;
    logic [1:0]          err_code_r;

    logic [3:0]          opcode_s;
    logic [CHAN_W-1:0]   chan_s;
    logic                chan_ok_s;
    logic                ack_sel_s;
    logic [NCHAN-1:0]    onehot_s;
    logic                acc_unused_s;

    function automatic logic [NCHAN-1:0] chan_onehot(input logic [CHAN_W-1:0] ch);
        logic [NCHAN-1:0] v;
        v     = {NCHAN{1'b0}};
        v[ch] = 1'b1;
        return v;
    endfunction

    assign acc_unused_s = ^{acc[DATA_W-1:8+CHAN_W], acc[7:4]};

    // Syscall field decode and selected-channel acknowledge
    always_comb begin
        opcode_s  = acc[3:0];
        chan_s    = acc[8 +: CHAN_W];
        chan_ok_s = 1'b0;
        if (32'(chan_s) < NCHAN) begin
            chan_ok_s = 1'b1;
        end else begin
            chan_ok_s = 1'b0;
        end
        onehot_s  = chan_onehot(chan_s);
        ack_sel_s = ioack[ch_r];
    end

`ifdef IO_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt_r;
`else
    localparam int tmo_unused = TIMEOUT + TIMEOUT_W;
`endif

    // Controller state, sticky flags and registered strobes; updates on the falling edge
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_DECODE;
            ch_r        <= {CHAN_W{1'b0}};
            err_done_r  <= 1'b0;
            iobusy_r    <= 1'b1;
            io_read_r   <= {NCHAN{1'b0}};
            io_write_r  <= {NCHAN{1'b0}};
            acc_write_r <= 1'b0;
            halted_r    <= 1'b0;
            ioerr_r     <= 1'b0;
            err_code_r  <= 2'd0;
`ifdef IO_TIMEOUT_EN
            tmo_cnt_r   <= {TIMEOUT_W{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_DECODE: begin
                    iobusy_r   <= 1'b1;
                    err_done_r <= 1'b0;
                    if (runio) begin
                        if (opcode_s == OP_HALT) begin
                            halted_r <= 1'b1;
                            state_r  <= ST_HALT;
                        end else if ((opcode_s == OP_LOAD) || (opcode_s == OP_STORE)) begin
                            if (chan_ok_s) begin
                                ch_r <= chan_s;
                                if (opcode_s == OP_LOAD) begin
                                    io_read_r   <= onehot_s;
                                    acc_write_r <= 1'b1;
                                end else begin
                                    io_write_r  <= onehot_s;
                                end
`ifdef IO_TIMEOUT_EN
                                tmo_cnt_r <= {TIMEOUT_W{1'b0}};
`endif
                                state_r <= ST_WAITACK;
                            end else begin
                                ioerr_r    <= 1'b1;
                                err_code_r <= ioerr_r ? err_code_r : ERR_CHANNEL;
                                iobusy_r   <= 1'b0;
                                err_done_r <= 1'b1;
                                state_r    <= ST_WAITREADY;
                            end
                        end else begin
                            ioerr_r    <= 1'b1;
                            err_code_r <= ioerr_r ? err_code_r : ERR_OPCODE;
                            iobusy_r   <= 1'b0;
                            err_done_r <= 1'b1;
                            state_r    <= ST_WAITREADY;
                        end
                    end else begin
                        state_r <= ST_DECODE;
                    end
                end
                ST_WAITACK: begin
                    if (ack_sel_s) begin
                        io_read_r   <= {NCHAN{1'b0}};
                        io_write_r  <= {NCHAN{1'b0}};
                        acc_write_r <= 1'b0;
                        iobusy_r    <= 1'b0;
                        state_r     <= ST_WAITREADY;
                    end
`ifdef IO_TIMEOUT_EN
                    // Ack on the expiry edge is checked first, so it completes normally
                    else if (tmo_cnt_r == TIMEOUT_W'(TIMEOUT - 1)) begin
                        io_read_r   <= {NCHAN{1'b0}};
                        io_write_r  <= {NCHAN{1'b0}};
                        acc_write_r <= 1'b0;
                        ioerr_r     <= 1'b1;
                        err_code_r  <= ioerr_r ? err_code_r : 2'd3;
                        iobusy_r    <= 1'b0;
                        state_r     <= ST_DECODE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
                    end
`else
                    else begin
                        state_r <= ST_WAITACK;
                    end
`endif
                end
                ST_WAITREADY: begin
                    iobusy_r <= 1'b1;
                    if (err_done_r || !ack_sel_s) begin
                        err_done_r <= 1'b0;
                        state_r    <= ST_DECODE;
                    end else begin
                        state_r <= ST_WAITREADY;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    io_read_r   <= {NCHAN{1'b0}};
                    io_write_r  <= {NCHAN{1'b0}};
                    acc_write_r <= 1'b0;
                    iobusy_r    <= 1'b1;
                    state_r     <= ST_DECODE;
                end
            endcase
        end
    end

    assign iobusy    = iobusy_r;
    assign io_read   = io_read_r;
    assign io_write  = io_write_r;
    assign acc_write = acc_write_r;
    assign halted    = halted_r;
    assign ioerr     = ioerr_r;
    assign err_code  = err_code_r;

endmodule

// File: tb/tb_iocontroller_mc.sv
// Directed bench for iocontroller_mc with a transaction-level reference model.
module tb_iocontroller_mc;

    localparam int NCHAN = 4;
    localparam int TMO   = 8;
`ifdef IO_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        runio;
    logic [15:0] acc;
    logic [3:0]  ioack;
    logic        iobusy;
    logic [3:0]  io_read;
    logic [3:0]  io_write;
    logic        acc_write;
    logic        halted;
    logic        ioerr;
    logic [1:0]  err_code;

    int n_total = 0;
    int n_bad   = 0;

    iocontroller_mc #(.DATA_W(16), .NCHAN(NCHAN), .CHAN_W(2), .TIMEOUT(TMO), .TIMEOUT_W(8)) dut (
        .clock(clock), .reset(reset), .runio(runio), .acc(acc), .ioack(ioack),
        .iobusy(iobusy), .io_read(io_read), .io_write(io_write), .acc_write(acc_write),
        .halted(halted), .ioerr(ioerr), .err_code(err_code)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int actual, input int expected);
        n_total++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    // Reference model: phase 0 idle, 1 transfer in flight, 2 completed/awaiting release, 3 halted
    int m_phase = 0;
    int m_ch = 0;
    bit m_load = 1'b0;
    bit m_pulse = 1'b0;
    bit m_err = 1'b0;
    int m_code = 0;
    bit m_errdone = 1'b0;
    int m_held = 0;

    task automatic m_error(input int code);
        if (!m_err) m_code = code;
        m_err = 1'b1;
        m_pulse = 1'b1;
    endtask

    always @(negedge clock or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_pulse = 1'b0; m_err = 1'b0; m_code = 0; m_errdone = 1'b0;
        end else begin
            int op, ch;
            m_pulse = 1'b0;
            op = int'(acc[3:0]);
            ch = int'(acc[9:8]);
            if (m_phase == 0) begin
                if (runio) begin
                    if (op == 0) m_phase = 3;
                    else if (op > 2) begin m_error(1); m_phase = 2; m_errdone = 1'b1; end
                    else if (ch >= NCHAN) begin m_error(2); m_phase = 2; m_errdone = 1'b1; end
                    else begin m_phase = 1; m_load = (op == 1); m_ch = ch; m_held = 0; end
                end
            end else if (m_phase == 1) begin
                m_held++;
                if (ioack[m_ch]) begin m_pulse = 1'b1; m_phase = 2; m_errdone = 1'b0; end
                else if (TMO_ON && m_held >= TMO) begin m_error(3); m_phase = 0; end
            end else if (m_phase == 2) begin
                if (m_errdone || !ioack[m_ch]) m_phase = 0;
            end
        end
    end

    // Compare process: outputs settle on the falling edge, so check on the rising edge
    always @(posedge clock) begin
        if (reset === 1'b1) begin
            int strobe;
            strobe = (m_phase == 1) ? (1 << m_ch) : 0;
            chk("iobusy", int'(iobusy), int'(!m_pulse));
            chk("io_read", int'(io_read), m_load ? strobe : 0);
            chk("io_write", int'(io_write), m_load ? 0 : strobe);
            chk("acc_write", int'(acc_write), int'(m_phase == 1 && m_load));
            chk("halted", int'(halted), int'(m_phase == 3));
            chk("ioerr", int'(ioerr), int'(m_err));
            chk("err_code", int'(err_code), m_code);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(2);
        chk("rst_iobusy", int'(iobusy), 1);
        chk("rst_strobes", int'({io_read, io_write, acc_write}), 0);
        chk("rst_flags", int'({halted, ioerr, err_code}), 0);
        reset = 1'b1;
        cyc(1);
    endtask

    initial begin
        reset = 1'b0; runio = 1'b0; acc = 16'h0000; ioack = 4'b0000;
        do_reset();

        // LOAD ch1, ack after 3 cycles
        acc = 16'h0101; runio = 1'b1;
        cyc(1); runio = 1'b0;
        chk("t1_read", int'(io_read), 2);
        chk("t1_accw", int'(acc_write), 1);
        acc = 16'h0302;
        cyc(2); ioack = 4'b0010;
        cyc(1);
        chk("t1_pulse", int'(iobusy), 0);
        chk("t1_drop", int'(io_read), 0);
        cyc(1);
        chk("t1_busy_back", int'(iobusy), 1);
        ioack = 4'b0000;
        cyc(2);

        // STORE ch3 with a stray ack on ch0
        acc = 16'h0302; runio = 1'b1;
        cyc(1); runio = 1'b0;
        chk("t2_write", int'(io_write), 8);
        ioack = 4'b0001;
        cyc(1);
        chk("t2_ignored", int'(io_write), 8);
        ioack = 4'b0000;
        cyc(1); ioack = 4'b1000;
        cyc(1);
        chk("t2_pulse", int'(iobusy), 0);
        ioack = 4'b0000;
        cyc(2);

        // Illegal opcode, then a syscall that must not disturb err_code
        acc = 16'h0005; runio = 1'b1;
        cyc(1); runio = 1'b0;
        chk("t3_err", int'({ioerr, err_code}), 5);
        chk("t3_pulse", int'(iobusy), 0);
        chk("t3_nostrobe", int'({io_read, io_write}), 0);
        cyc(2);
        acc = 16'h0701; runio = 1'b1;
        cyc(1); runio = 1'b0;
        chk("t3_code_kept", int'(err_code), 1);
        ioack = 4'b1000;
        cyc(1); ioack = 4'b0000;
        cyc(2);
        // runio held high: back-to-back illegal syscalls re-enter on each return
        acc = 16'h000F; runio = 1'b1;
        cyc(6); runio = 1'b0;
        cyc(2);

        // HALT is terminal
        acc = 16'h0000; runio = 1'b1;
        cyc(1);
        chk("t4_halted", int'(halted), 1);
        chk("t4_busy", int'(iobusy), 1);
        acc = 16'h0101; ioack = 4'b1111;
        cyc(3); runio = 1'b0; ioack = 4'b0000;
        chk("t4_nostrobe", int'({io_read, acc_write}), 0);
        cyc(1);

        // Reset between edges while io_write[2] is high
        do_reset();
        acc = 16'h0202; runio = 1'b1;
        cyc(1); runio = 1'b0;
        chk("t5_write", int'(io_write), 4);
        #2 reset = 1'b0;
        #1;
        chk("t5_async_strobe", int'({io_read, io_write, acc_write}), 0);
        chk("t5_async_busy", int'(iobusy), 1);
        cyc(1);
        reset = 1'b1;
        cyc(1);

`ifdef IO_TIMEOUT_EN
        // LOAD ch0 never acked: strobe held 8 cycles then timeout error
        do_reset();
        acc = 16'h0001; runio = 1'b1;
        cyc(1); runio = 1'b0;
        cyc(7);
        chk("t6_held", int'(io_read), 1);
        cyc(1);
        chk("t6_expired", int'(io_read), 0);
        chk("t6_code", int'({ioerr, err_code}), 7);
        cyc(2);
        // Ack on the expiry cycle completes cleanly
        do_reset();
        acc = 16'h0001; runio = 1'b1;
        cyc(1); runio = 1'b0;
        cyc(7); ioack = 4'b0001;
        cyc(1);
        chk("t6_clean_pulse", int'(iobusy), 0);
        chk("t6_clean_err", int'(ioerr), 0);
        ioack = 4'b0000;
        cyc(2);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
